pll_mdrp_ctrl: RTL and testbench
================================

Name: pll_mdrp_ctrl

Overview:
- Initiator for the PLLA dynamic-reconfiguration (MDRP) port: drives mdopc/mdainc/mdwdi and samples mdrdo.
- Exposes a simple command/response interface to the host (UART/USB command decoder) for single-register read, write, and masked read-modify-write.
- Instantiated beside the PLL wrapper; the same clk feeds the wrapper's mdclk.

Parameters:
- RD_LAT, 2, cycles from the read address cycle to valid mdrdo (1..7).
- RST_CYCLES, 16, pll_reset pulse width after a write (PLL_RELOCK_EN only).
- LOCK_TIMEOUT, 65535, max cycles waiting for pll_lock after reset release (PLL_RELOCK_EN only).
- CNT_W, 16, width of the shared wait counter; must hold max(RD_LAT, RST_CYCLES, LOCK_TIMEOUT).

Ports:
- clk  in  1  system clock; also the PLL mdclk.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write/RMW, 0=read.
- cmd_addr  in  8  MDRP register address.
- cmd_wdata  in  8  write data.
- cmd_mask  in  8  bit-enable for writes; 8'hFF = plain write.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  8  read data (read/RMW: value before modify; plain write: 0).
- rsp_err  out  1  relock timeout.
- busy  out  1  state != IDLE.
- mdopc  out  2  MDRP opcode: 00 NOP, 01 WRITE, 10 READ.
- mdainc  out  1  address auto-increment; held 0.
- mdwdi  out  8  MDRP address/data bus.
- mdrdo  in  8  MDRP read data.
- pll_reset  out  1  PLL reset request.
- pll_lock  in  1  PLL lock status; synchronised internally with a 2 FF synchroniser.

Behaviour:
- Reset values:
  - cmd_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - busy=0
  - mdopc=00, mdainc=0, mdwdi=0
  - pll_reset=0
  - state=IDLE, counter=0
- Accept when cmd_valid && cmd_ready at edge T. Latch addr, wdata, mask, and the op.
- States and transitions:
  - IDLE -> RD_ADDR for reads and masked writes (mask != FF).
  - IDLE -> WR_ADDR for mask == FF.
  - RD_ADDR: mdopc=10, mdwdi=addr for exactly one cycle. Then RD_WAIT.
  - RD_WAIT: mdopc=00, mdwdi=0. Count RD_LAT-1 cycles, then capture mdrdo in the next cycle (RD_CAP).
  - A read capture happens in the cycle RD_LAT after the address cycle.
  - Read: rsp_valid one cycle after capture, i.e. at T+2+RD_LAT.
  - RMW: merged = (rd & ~mask) | (wdata & mask), then go to WR_ADDR.
  - WR_ADDR: mdopc=01, mdwdi=addr for one cycle.
  - WR_DATA: mdopc=00, mdwdi=data for one cycle.
  - After WR_DATA: go to RESP. With PLL_RELOCK_EN, go to PLL_RST instead.
  - RESP: rsp_valid=1 for one cycle, then back to IDLE.
- Plain write latency: addr cycle T+1, data cycle T+2, rsp_valid at T+3.
- mdopc returns to 00 in every cycle not listed above. Two non-NOP opcodes are never issued back to back.
- cmd_valid while busy is ignored; no queueing.
- rsp_rdata and rsp_err hold until the next response.
- Reset mid-operation: on the next edge all outputs take reset values. No response is emitted, and the partial transaction is abandoned.
- Simultaneous rsp pulse and new cmd_valid: not accepted that cycle (cmd_ready=0 in RESP).

Optional Feature:
- Macro: PLL_RELOCK_EN.
- Defined: after WR_DATA, enter PLL_RST.
  - pll_reset=1 for RST_CYCLES cycles, then 0.
  - LOCK_WAIT: wait for synchronised lock=1 → RESP with rsp_err=0.
  - If LOCK_TIMEOUT cycles elapse without lock → RESP with rsp_err=1.
  - A read never triggers relock.
- Undefined:
  - PLL_RST and LOCK_WAIT states are absent.
  - pll_reset is tied 0 and pll_lock is unused.
  - rsp_err is always 0.

Decomposition:
- Package pll_mdrp_pkg:
  - MDOPC_NOP/WRITE/READ constants.
  - state enum.
  - RD_LAT default.
- No sub-module is needed except the pll_lock 2-FF synchroniser, which reuses the team's existing sync_ff cell.
- Single FSM plus one shared wait counter.

Test Plan:
- Read, RD_LAT=2, addr 8'h12, bench PLL model returns 8'hA5 → mdopc=10 with mdwdi=12 at T+1; rsp_valid at T+4 with rsp_rdata=A5.
- Plain write: addr 8'h20, data 8'h3C, mask FF → mdopc=01/mdwdi=20 at T+1; mdopc=00/mdwdi=3C at T+2; rsp_valid at T+3; model register equals 3C.
- RMW: register 20 holds F0, wdata 0F, mask 0C → one read then one write; register becomes FC; rsp_rdata=F0.
- PLL_RELOCK_EN, model lock returns 50 cycles after reset release → pll_reset high exactly 16 cycles; rsp_err=0.
- PLL_RELOCK_EN, LOCK_TIMEOUT=100, lock held low → rsp_valid after 100 wait cycles with rsp_err=1.
- rst_n low during WR_ADDR → next edge mdopc=00, busy=0, no rsp_valid; a following read command completes normally.

Source files
------------

// File: rtl/pll_mdrp_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the PLLA MDRP controller.
// States PLL_RST and LOCK_WAIT exist only when PLL_RELOCK_EN is defined.
package pll_mdrp_pkg;

  localparam logic [1:0] MDOPC_NOP   = 2'b00;
  localparam logic [1:0] MDOPC_WRITE = 2'b01;
  localparam logic [1:0] MDOPC_READ  = 2'b10;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR_ADDR,
    ST_WR_DATA,
`ifdef PLL_RELOCK_EN
    ST_PLL_RST,
    ST_LOCK_WAIT,
`endif
    ST_RESP
  } state_t;

  // Bits selected by mask come from the new data, the rest keep the old value.
  function automatic logic [7:0] merge_bits(input logic [7:0] old_val,
                                            input logic [7:0] new_val,
                                            input logic [7:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous level input.
// Synchronous active-low reset clears every stage.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// MDRP initiator for the PLLA: single read, write and masked read-modify-write.
// Define PLL_RELOCK_EN to pulse pll_reset after every write and wait for relock.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = 16
`ifdef PLL_RELOCK_EN
  ,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [7:0]       mask_q;
  logic [7:0]       old_q;
  logic             write_q;

`ifdef PLL_RELOCK_EN
  logic lock_s;
  logic pll_reset_q;

  sync_ff #(.STAGES(2)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign pll_reset = pll_reset_q;
`else
  logic unused_lock;
  assign unused_lock = pll_lock;
  assign pll_reset   = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mdainc    = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      old_q     <= '0;
      write_q   <= 1'b0;
      mdopc     <= MDOPC_NOP;
      mdwdi     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef PLL_RELOCK_EN
      pll_reset_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults here make every MDRP opcode and response a
      // single-cycle pulse unless a state below re-asserts it.
      mdopc     <= MDOPC_NOP;
      mdwdi     <= '0;
      rsp_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            data_q  <= cmd_wdata;
            mask_q  <= cmd_mask;
            write_q <= cmd_write;
            old_q   <= '0;
            mdwdi   <= cmd_addr;
            if (!cmd_write || cmd_mask != 8'hFF) begin
              state <= ST_RD_ADDR;
              mdopc <= MDOPC_READ;
            end else begin
              state <= ST_WR_ADDR;
              mdopc <= MDOPC_WRITE;
            end
          end
        end

        ST_RD_ADDR: begin
          cnt   <= '0;
          state <= (RD_LAT == 1) ? ST_RD_CAP : ST_RD_WAIT;
        end

        // Stays RD_LAT-1 cycles so that RD_CAP lines up with valid mdrdo.
        ST_RD_WAIT: begin
          if (cnt == CNT_W'(RD_LAT - 2)) state <= ST_RD_CAP;
          else                           cnt   <= cnt + 1'b1;
        end

        ST_RD_CAP: begin
          if (write_q) begin
            old_q  <= mdrdo;
            data_q <= merge_bits(mdrdo, data_q, mask_q);
            mdopc  <= MDOPC_WRITE;
            mdwdi  <= addr_q;
            state  <= ST_WR_ADDR;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mdrdo;
            rsp_err   <= 1'b0;
            state     <= ST_RESP;
          end
        end

        ST_WR_ADDR: begin
          mdwdi <= data_q;
          state <= ST_WR_DATA;
        end

        ST_WR_DATA: begin
`ifdef PLL_RELOCK_EN
          pll_reset_q <= 1'b1;
          cnt         <= '0;
          state       <= ST_PLL_RST;
`else
          rsp_valid <= 1'b1;
          rsp_rdata <= old_q;
          rsp_err   <= 1'b0;
          state     <= ST_RESP;
`endif
        end

`ifdef PLL_RELOCK_EN
        ST_PLL_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            pll_reset_q <= 1'b0;
            cnt         <= '0;
            state       <= ST_LOCK_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LOCK_WAIT: begin
          if (lock_s || cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= old_q;
            rsp_err   <= !lock_s;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Self-checking bench for pll_mdrp_ctrl: PLL register model plus a reference
// register map; covers PLL_RELOCK_EN when that macro is defined.
module tb_pll_mdrp_ctrl;

  localparam int TB_RD_LAT = 2;
  localparam int TB_RST    = 16;
  localparam int TB_TO     = 100;
  localparam int LAT_BOUND = 400;
`ifdef PLL_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       pll_reset;
  logic       pll_lock;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_mdrp_ctrl #(
    .RD_LAT (TB_RD_LAT),
    .CNT_W  (16)
`ifdef PLL_RELOCK_EN
    ,
    .RST_CYCLES   (TB_RST),
    .LOCK_TIMEOUT (TB_TO)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_mask  (cmd_mask),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo),
    .pll_reset (pll_reset),
    .pll_lock  (pll_lock)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // PLL-side register model: reads return data RD_LAT cycles after the
  // address cycle (junk otherwise); a write is an address cycle plus data cycle.
  logic [7:0] pll_regs [256];
  bit         init_done = 1'b0;
  int         since_rd  = -1;
  logic [7:0] rd_addr;
  bit         wr_pend   = 1'b0;
  logic [7:0] wr_addr;
  int         n_rd_ops  = 0;
  int         n_wr_ops  = 0;
  int         n_b2b     = 0;
  logic [1:0] prev_op   = 2'b00;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) pll_regs[i] = init_val(i);
      init_done = 1'b1;
    end
    if (since_rd >= 0) since_rd++;
    if (wr_pend) begin
      if (rst_n) pll_regs[wr_addr] = mdwdi;
      wr_pend = 1'b0;
    end
    if (mdopc == 2'b10) begin
      rd_addr  = mdwdi;
      since_rd = 0;
      n_rd_ops++;
    end
    if (mdopc == 2'b01) begin
      wr_addr = mdwdi;
      wr_pend = 1'b1;
      n_wr_ops++;
    end
    if (mdopc != 2'b00 && prev_op != 2'b00) n_b2b++;
    prev_op = mdopc;
    if (since_rd == TB_RD_LAT - 1) mdrdo <= pll_regs[rd_addr];
    else                           mdrdo <= 8'($urandom);
  end

`ifdef PLL_RELOCK_EN
  bit lock_mode = 1'b1;
  int lock_cnt  = 0;
  // Lock drops while pll_reset is high and returns 50 cycles after release.
  always @(posedge clk) begin
    if (pll_reset) begin
      pll_lock <= 1'b0;
      lock_cnt = 0;
    end else if (lock_mode && pll_lock !== 1'b1) begin
      lock_cnt++;
      if (lock_cnt == 50) pll_lock <= 1'b1;
    end
  end
`else
  bit lock_mode = 1'b1;
  assign pll_lock = 1'b0;
`endif

  logic [7:0] ref_regs [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from IDLE through its response; expected values come from
  // ref_regs and the documented cycle counts.
  task automatic run_op(input logic wr, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] m, input bit junk);
    logic [7:0] exp_rdata;
    int exp_lat, exp_rd, exp_wr, exp_rst_hi, lat, rst_hi, rd0, wr0, b2b0, ainc;
    bit exp_err;
    exp_rdata  = (wr && m == 8'hFF) ? 8'h00 : ref_regs[a];
    exp_rd     = (!wr || m != 8'hFF) ? 1 : 0;
    exp_wr     = wr ? 1 : 0;
    exp_rst_hi = (RELOCK && wr) ? TB_RST : 0;
    exp_err    = RELOCK && wr && !lock_mode;
    if (!wr)              exp_lat = 2 + TB_RD_LAT;
    else if (m == 8'hFF)  exp_lat = 3;
    else                  exp_lat = 4 + TB_RD_LAT;
    if (RELOCK && wr) exp_lat = lock_mode ? -1 : exp_lat + TB_RST + TB_TO;
    if (wr) ref_regs[a] = (ref_regs[a] & ~m) | (w & m);

    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = w; cmd_mask = m;
    rd0 = n_rd_ops; wr0 = n_wr_ops; b2b0 = n_b2b;
    lat = 0; rst_hi = 0; ainc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (pll_reset) rst_hi++;
      if (mdainc !== 1'b0) ainc++;
      if (lat == 1) begin
        check("first_opc", mdopc, exp_rd ? 2'b10 : 2'b01);
        check("first_addr", mdwdi, a);
        check("busy_ready", {busy, cmd_ready}, 2'b10);
        if (junk) begin
          cmd_write = 1'b1; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
          cmd_mask = 8'hFF;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end while (rsp_valid !== 1'b1 && lat < LAT_BOUND);
    check("rsp_seen", rsp_valid, 1);
    if (exp_lat >= 0) check("rsp_latency", lat, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("pll_reset_cycles", rst_hi, exp_rst_hi);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("idle_after_resp", {busy, rsp_valid}, 2'b00);
    check("hold_rdata", rsp_rdata, exp_rdata);
    check("rd_ops", n_rd_ops - rd0, exp_rd);
    check("wr_ops", n_wr_ops - wr0, exp_wr);
    check("no_b2b_opc", n_b2b - b2b0, 0);
    check("mdainc_zero", ainc, 0);
    check("pll_reg", pll_regs[a], ref_regs[a]);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, w, m;
    logic       wr;
    for (int i = 0; i < 256; i++) ref_regs[i] = init_val(i);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_busy", {cmd_ready, busy}, 2'b10);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h0);
    check("reset_md", {mdopc, mdainc, mdwdi}, 11'h0);
    check("reset_pll_reset", pll_reset, 0);
    rst_n = 1'b1;

    // Directed: write then read A5 at 12, plain write 3C at 20, RMW F0 -> FC.
    run_op(1'b1, 8'h12, 8'hA5, 8'hFF, 1'b0);
    run_op(1'b0, 8'h12, 8'h00, 8'h00, 1'b0);
    run_op(1'b1, 8'h20, 8'h3C, 8'hFF, 1'b0);
    check("reg20_3c", pll_regs[8'h20], 8'h3C);
    run_op(1'b1, 8'h20, 8'hF0, 8'hFF, 1'b0);
    run_op(1'b1, 8'h20, 8'h0F, 8'h0C, 1'b0);
    check("reg20_fc", pll_regs[8'h20], 8'hFC);
    run_op(1'b1, 8'h21, 8'h55, 8'h00, 1'b1);

`ifdef PLL_RELOCK_EN
    lock_mode = 1'b0;
    run_op(1'b1, 8'h30, 8'h99, 8'hFF, 1'b0);
    run_op(1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
    lock_mode = 1'b1;
`endif

    for (int n = 0; n < 24; n++) begin
      a  = 8'h40 + 8'($urandom_range(0, 7));
      wr = 1'($urandom);
      w  = 8'($urandom);
      m  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_op(wr, a, w, m, 1'($urandom));
    end

    // Reset while the write address cycle is on the bus.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50;
    cmd_wdata = ~ref_regs[8'h50]; cmd_mask = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_wr_addr", mdopc, 2'b01);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_md", {mdopc, mdwdi}, 10'h0);
    check("mid_rst_state", {busy, cmd_ready, rsp_valid}, 3'b010);
    check("mid_rst_rsp", {rsp_err, rsp_rdata}, 9'h0);
    @(negedge clk);
    check("mid_rst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    run_op(1'b0, 8'h50, 8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
